pwm_generator: RTL and testbench
================================

Name: pwm_generator

Overview:
- Consumes the top/compare stream produced by the PWM sequencer and drives a single PWM output pin, e.g. an LED.
- Free-running period counter with double-buffered top and compare: values arriving on valid strobes go into shadow registers and take effect only at the next period boundary, so no glitched or partial periods occur.
- The output is registered and has 100%-duty capability: compare = top+1 gives a constantly high output.

Parameters:
- WIDTH, 8, width of top and of the period counter; compare is WIDTH+1 bits.
- RESET_TOP, 2**WIDTH-1, active/shadow top value after reset.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  asynchronous, active-high reset
- i_top  input  WIDTH  period top value; the counter runs 0..top
- i_top_valid  input  1  single-cycle strobe; captures i_top into the shadow register
- i_compare  input  WIDTH+1  duty compare value
- i_compare_valid  input  1  single-cycle strobe; captures i_compare into the shadow register
- o_pwm  output  1  registered PWM output
- o_period_start  output  1  registered one-cycle pulse, coincident with o_pwm showing count 0
- o_count  output  WIDTH  current counter value, for debug and verification

Behaviour:
- Reset (asynchronous assert, synchronous release on i_clk):
  - counter = 0
  - shadow_top = active_top = RESET_TOP
  - shadow_cmp = active_cmp = 0
  - o_pwm = 0, o_period_start = 0, o_count = 0
- Shadow capture: on any cycle with i_top_valid=1, shadow_top <= i_top. i_compare_valid behaves the same way for shadow_cmp.
  - The two strobes are independent; either or both may fire in any cycle.
  - Last write before the boundary wins.
- Counter: if count == active_top, count <= 0 (the wrap); otherwise count <= count+1.
- Reload at the wrap cycle (count == active_top):
  - active_top <= shadow_top and active_cmp <= shadow_cmp.
  - Bypass: if a valid strobe fires in the wrap cycle itself, the incoming input value is loaded directly into active (and shadow). It is not delayed one period.
- Output compare, one cycle latency from the counter:
  - o_pwm <= (count < active_cmp), unsigned, WIDTH+1-bit compare.
  - o_period_start <= (count == 0).
  - o_count mirrors the counter register (no extra delay); o_pwm lags o_count by 1 cycle.
- Duty rules (period = active_top+1 cycles):
  - compare=0: constant low.
  - compare>=top+1: constant high.
  - otherwise: exactly `compare` high cycles per period, high first.
- Top changes:
  - Take effect only at a wrap; a smaller top never strands the counter above top.
  - top=0: counter stays at 0 and wraps every cycle; reload happens every cycle; o_period_start is constant 1 after the first cycle.
- Reset mid-period: everything returns to reset values immediately (asynchronously); the first period after release starts at count 0 with RESET_TOP.

Optional Feature:
- Macro: PWM_PHASE_CORRECT_EN.
- Defined: counter is up/down (center-aligned) with an internal direction bit, reset = up.
  - Sequence: 0,1,…,top,top-1,…,1, then 0 again. The period is 2*top cycles for top>=1.
  - Reload and o_period_start occur only at count==0 in the down direction, or at the first 0 after reset. The bypass rule applies in that cycle.
  - o_pwm rule is unchanged (count < active_cmp). This gives symmetric pulses of 2*cmp-1 high cycles for 1<=cmp<=top; cmp=0 is constant low and cmp>top is constant high.
  - top=0: counter holds at 0, period 1.
- Not defined: edge-aligned up-counter only, as above. No direction logic is synthesized.

Test Plan:
- Reset with no strobes -> o_pwm stays 0 for 600 cycles; o_period_start pulses every 256 cycles; o_count runs 0..255.
- top=3, then compare=2 loaded mid-period -> old duty holds until the wrap; afterwards o_pwm repeats 1,1,0,0 with o_period_start on each first 1.
- top=3, compare=4 -> o_pwm constant 1. compare=0 -> constant 0 from the next period, with no single-cycle glitch.
- Strobe top=1 in the exact wrap cycle -> period becomes 2 immediately (bypass). Strobe top=1 one cycle after the wrap -> old top persists one full extra period.
- Assert i_reset for 1 cycle while count=100, top=255, compare=128 -> outputs 0 immediately; after release compare=0, top=255, count restarts at 0.
- With PWM_PHASE_CORRECT_EN: top=4, compare=2 -> o_count 0,1,2,3,4,3,2,1,0…; o_pwm (1 cycle later) 1,1,0,0,0,0,0,1 repeating, period 8.

Source files
------------

// File: rtl/pwm_generator.sv
// Double-buffered PWM generator: free-running period counter, shadowed top/compare, 0..100% duty.
// Define PWM_PHASE_CORRECT_EN to build a center-aligned up/down counter instead of edge-aligned.
module pwm_generator #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_TOP = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_top,
  input  logic             i_top_valid,
  input  logic [WIDTH:0]   i_compare,
  input  logic             i_compare_valid,
  output logic             o_pwm,
  output logic             o_period_start,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH:0]   CMP_ZERO = {(WIDTH+1){1'b0}};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] active_top_r;
  logic [WIDTH-1:0] shadow_top_r;
  logic [WIDTH-1:0] new_top_s;
  logic [WIDTH:0]   active_cmp_r;
  logic [WIDTH:0]   shadow_cmp_r;
  logic [WIDTH:0]   new_cmp_s;
  logic             wrap_s;
  logic             pwm_r;
  logic             period_start_r;

  // Values loaded into the active registers at a wrap; a strobe in that same cycle bypasses the shadow.
  always_comb begin
    new_top_s = shadow_top_r;
    new_cmp_s = shadow_cmp_r;
    if (i_top_valid) begin
      new_top_s = i_top;
    end else begin
      new_top_s = shadow_top_r;
    end
    if (i_compare_valid) begin
      new_cmp_s = i_compare;
    end else begin
      new_cmp_s = shadow_cmp_r;
    end
  end

`ifdef PWM_PHASE_CORRECT_EN
  logic dir_down_r;
  logic dir_down_nxt_s;

  // Count 0 only appears at the bottom of a down slope (or straight after reset), so it marks the reload.
  assign wrap_s = (count_r == CNT_ZERO);

  // Up/down sequencing 0,1..top,top-1..1; a zero top parks the counter at 0.
  always_comb begin
    count_nxt_s    = count_r;
    dir_down_nxt_s = dir_down_r;
    if (wrap_s) begin
      dir_down_nxt_s = 1'b0;
      if (new_top_s == CNT_ZERO) begin
        count_nxt_s = CNT_ZERO;
      end else begin
        count_nxt_s = CNT_ONE;
      end
    end else if (dir_down_r) begin
      count_nxt_s    = count_r - CNT_ONE;
      dir_down_nxt_s = 1'b1;
    end else if (count_r == active_top_r) begin
      count_nxt_s    = count_r - CNT_ONE;
      dir_down_nxt_s = 1'b1;
    end else begin
      count_nxt_s    = count_r + CNT_ONE;
      dir_down_nxt_s = 1'b0;
    end
  end

  // Direction register, reset to counting up.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dir_down_r <= 1'b0;
    end else begin
      dir_down_r <= dir_down_nxt_s;
    end
  end
`else
  assign wrap_s = (count_r == active_top_r);

  // Edge-aligned up-counter: wraps to 0 after reaching the active top.
  always_comb begin
    count_nxt_s = count_r;
    if (wrap_s) begin
      count_nxt_s = CNT_ZERO;
    end else begin
      count_nxt_s = count_r + CNT_ONE;
    end
  end
`endif

  // Counter, shadow/active buffers and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_r        <= CNT_ZERO;
      shadow_top_r   <= RESET_TOP;
      active_top_r   <= RESET_TOP;
      shadow_cmp_r   <= CMP_ZERO;
      active_cmp_r   <= CMP_ZERO;
      pwm_r          <= 1'b0;
      period_start_r <= 1'b0;
    end else begin
      count_r      <= count_nxt_s;
      shadow_top_r <= new_top_s;
      shadow_cmp_r <= new_cmp_s;
      if (wrap_s) begin
        active_top_r <= new_top_s;
        active_cmp_r <= new_cmp_s;
      end else begin
        active_top_r <= active_top_r;
        active_cmp_r <= active_cmp_r;
      end
      // Compare is one bit wider than the counter so compare = top+1 yields a constant high.
      pwm_r          <= ({1'b0, count_r} < active_cmp_r);
      period_start_r <= (count_r == CNT_ZERO);
    end
  end

  assign o_pwm          = pwm_r;
  assign o_period_start = period_start_r;
  assign o_count        = count_r;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: directed vector table plus random strobes against a period-queue model.
module tb_pwm_generator;

  localparam int W = 8;
  localparam int RESET_TOP = 255;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [W-1:0] i_top;
  logic         i_top_valid;
  logic [W:0]   i_compare;
  logic         i_compare_valid;
  logic         o_pwm;
  logic         o_period_start;
  logic [W-1:0] o_count;

  pwm_generator #(.WIDTH(W)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_top           (i_top),
    .i_top_valid     (i_top_valid),
    .i_compare       (i_compare),
    .i_compare_valid (i_compare_valid),
    .o_pwm           (o_pwm),
    .o_period_start  (o_period_start),
    .o_count         (o_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each period is expanded into a queue of (count, pwm) slots from the
  // top/compare in force; popping the last slot of a period is the reload point.
  typedef struct {
    int cnt;
    bit pwm;
  } slot_t;

  slot_t q[$];
  int    m_shadow_top;
  int    m_shadow_cmp;
  int    m_count;
  bit    m_pwm;
  bit    m_ps;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic slot_t mk(input int c, input int cmp);
    slot_t s;
    s.cnt = c;
    s.pwm = (c < cmp);
    return s;
  endfunction

  task automatic fill_period(input int top, input int cmp);
`ifdef PWM_PHASE_CORRECT_EN
    if (top > 0) begin
      for (int k = 1; k <= top; k++) q.push_back(mk(k, cmp));
      for (int k = top - 1; k >= 1; k--) q.push_back(mk(k, cmp));
    end
    q.push_back(mk(0, cmp));
`else
    for (int k = 0; k <= top; k++) q.push_back(mk(k, cmp));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_shadow_top = RESET_TOP;
    m_shadow_cmp = 0;
`ifdef PWM_PHASE_CORRECT_EN
    q.push_back(mk(0, 0));
`else
    fill_period(RESET_TOP, 0);
`endif
    m_count = 0;
    m_pwm   = 1'b0;
    m_ps    = 1'b0;
  endtask

  task automatic model_edge();
    if (i_top_valid) m_shadow_top = int'(i_top);
    if (i_compare_valid) m_shadow_cmp = int'(i_compare);
    m_pwm = q[0].pwm;
    m_ps  = (q[0].cnt == 0);
    void'(q.pop_front());
    if (q.size() == 0) fill_period(m_shadow_top, m_shadow_cmp);
    m_count = q[0].cnt;
  endtask

  task automatic step(input logic tv, input int top, input logic cv, input int cmp);
    logic [31:0] t32;
    logic [31:0] c32;
    t32 = top;
    c32 = cmp;
    i_top_valid     = tv;
    i_top           = t32[W-1:0];
    i_compare_valid = cv;
    i_compare       = c32[W:0];
    @(posedge clk);
    model_edge();
    @(negedge clk);
    i_top_valid     = 1'b0;
    i_compare_valid = 1'b0;
    check("model_count", int'(o_count), m_count);
    check("model_pwm", int'(o_pwm), int'(m_pwm));
    check("model_period_start", int'(o_period_start), int'(m_ps));
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    model_reset();
    check("reset_count", int'(o_count), 0);
    check("reset_pwm", int'(o_pwm), 0);
    check("reset_period_start", int'(o_period_start), 0);
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget);
    int n;
    n = 0;
    while ((int'(o_count) != target) && (n < budget)) begin
      step(1'b0, 0, 1'b0, 0);
      n++;
    end
    check("wait_count_reached", int'(o_count), target);
  endtask

  typedef struct {
    logic tv;
    int   top;
    logic cv;
    int   cmp;
    int   e_cnt;
    logic e_pwm;
    logic e_ps;
  } vec_t;

  vec_t tbl[32];

  initial begin
    // Directed sequence from count 0 with top=3, compare=0 active.
    tbl[0]  = '{1'b0, 0, 1'b0, 0, 1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 0, 1'b1, 2, 2, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 0, 1'b0, 0, 3, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 0, 1'b0, 0, 1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 0, 1'b0, 0, 2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 0, 1'b0, 0, 3, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 0, 1'b1, 4, 1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 0, 1'b0, 0, 2, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 0, 1'b0, 0, 3, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 0, 1'b0, 0, 1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 0, 1'b0, 0, 2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 0, 1'b1, 0, 3, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 0, 1'b0, 0, 1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 0, 1'b0, 0, 2, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 0, 1'b0, 0, 3, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 0, 1'b0, 0, 1, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 0, 1'b1, 1, 1, 1'b0, 1'b1};
    tbl[23] = '{1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 0, 1'b0, 0, 1, 1'b1, 1'b1};
    tbl[25] = '{1'b1, 3, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[26] = '{1'b1, 1, 1'b0, 0, 1, 1'b1, 1'b1};
    tbl[27] = '{1'b0, 0, 1'b0, 0, 2, 1'b0, 1'b0};
    tbl[28] = '{1'b0, 0, 1'b0, 0, 3, 1'b0, 1'b0};
    tbl[29] = '{1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[30] = '{1'b0, 0, 1'b0, 0, 1, 1'b1, 1'b1};
    tbl[31] = '{1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};

    i_top           = '0;
    i_top_valid     = 1'b0;
    i_compare       = '0;
    i_compare_valid = 1'b0;
    do_reset();

    // Idle after reset: constant low output, 256-cycle periods.
    for (int i = 0; i < 600; i++) step(1'b0, 0, 1'b0, 0);

`ifndef PWM_PHASE_CORRECT_EN
    step(1'b1, 3, 1'b0, 0);
    wait_count(0, 400);
    for (int i = 0; i < 32; i++) begin
      step(tbl[i].tv, tbl[i].top, tbl[i].cv, tbl[i].cmp);
      check($sformatf("vec%0d_count", i), int'(o_count), tbl[i].e_cnt);
      check($sformatf("vec%0d_pwm", i), int'(o_pwm), int'(tbl[i].e_pwm));
      check($sformatf("vec%0d_period_start", i), int'(o_period_start), int'(tbl[i].e_ps));
    end
`endif

    // Reset mid-period with top=255, compare=128 in force.
    step(1'b1, 255, 1'b1, 128);
    wait_count(0, 600);
    wait_count(100, 600);
    check("pre_reset_pwm_high", int'(o_pwm), 1);
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b0, 0, 1'b0, 0);

    // Random strobes, biased toward short periods and boundary compares.
    for (int i = 0; i < 2500; i++) begin
      int   top;
      int   cmp;
      int   r;
      logic tv;
      logic cv;
      r = int'($urandom_range(0, 9));
      if (r == 0) top = 0;
      else if (r == 1) top = 255;
      else top = int'($urandom_range(1, 12));
      cmp = int'($urandom_range(0, 14));
      if (cmp > 256) cmp = 256;
      tv = ($urandom_range(0, 7) == 0);
      cv = ($urandom_range(0, 5) == 0);
      if (i == 1200) do_reset();
      step(tv, top, cv, cmp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
